// File: rtl/dac4_ctrl_pkg.sv
// dac4 sweep controller shared types.
// Mode encodings, FSM states, default widths.
package dac4_ctrl_pkg;

  localparam int CODE_W_DEF = 4;
  localparam int DIV_W_DEF  = 8;

  typedef enum logic [1:0] {
    MODE_UP_ONCE   = 2'd0,
    MODE_SAW       = 2'd1,
    MODE_TRI       = 2'd2,
    MODE_DOWN_ONCE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

endpackage

// File: rtl/dac4_sweep_ctrl_if.sv
// dac4 sweep controller control/status bundle.
// master = register side, slave = sequencer.
interface dac4_sweep_ctrl_if #(
  parameter int CODE_W = 4,
  parameter int DIV_W  = 8
);
  logic              start;
  logic              stop;
  logic [1:0]        mode;
  logic [CODE_W-1:0] code_lo;
  logic [CODE_W-1:0] code_hi;
  logic [DIV_W-1:0]  dwell;
  logic [CODE_W-1:0] code;
  logic              step_stb;
  logic              period_stb;
  logic              busy;
  logic              done;
  logic              cfg_err;

  modport master (
    output start, stop, mode,
    output code_lo, code_hi, dwell,
    input  code, step_stb, period_stb,
    input  busy, done, cfg_err
  );

  modport slave (
    input  start, stop, mode,
    input  code_lo, code_hi, dwell,
    output code, step_stb, period_stb,
    output busy, done, cfg_err
  );
endinterface

// File: rtl/dac4_dwell_timer.sv
// Loadable down-counter for code dwell.
// expire is high in the last cycle of a loaded count.
module dac4_dwell_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             expire
);

  logic [DIV_W-1:0] cnt_q;

  // count down after a load, park at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == DIV_W'(1));

endmodule

// File: rtl/dac4_sweep_ctrl.sv
// dac4 code sequencer: ramp, sawtooth, triangle.
// Config latched per run, code steps every dwell.
module dac4_sweep_ctrl
  import dac4_ctrl_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input logic              clk,
  input logic              rst,
  dac4_sweep_ctrl_if.slave bus
);

  state_e            state_q, state_n;
  mode_e             mode_q, mode_n;
  logic [CODE_W-1:0] lo_q, lo_n;
  logic [CODE_W-1:0] hi_q, hi_n;
  logic [DIV_W-1:0]  d_q, d_n;
  logic [CODE_W-1:0] code_q, code_n;
  logic              step_q, step_n;
  logic              per_q, per_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              err_q, err_n;
  logic              load;
  logic [DIV_W-1:0]  load_val;
  logic [DIV_W-1:0]  dw_in;
  logic              expire;

  assign dw_in = (bus.dwell == '0) ? DIV_W'(1) : bus.dwell;

  dac4_dwell_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  // state, latched config and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_UP_ONCE;
      lo_q    <= '0;
      hi_q    <= '0;
      d_q     <= DIV_W'(1);
      code_q  <= '0;
      step_q  <= 1'b0;
      per_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      mode_q  <= mode_n;
      lo_q    <= lo_n;
      hi_q    <= hi_n;
      d_q     <= d_n;
      code_q  <= code_n;
      step_q  <= step_n;
      per_q   <= per_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // next state, next code and strobes
  always_comb begin
    state_n  = state_q;
    mode_n   = mode_q;
    lo_n     = lo_q;
    hi_n     = hi_q;
    d_n      = d_q;
    code_n   = code_q;
    step_n   = 1'b0;
    per_n    = 1'b0;
    done_n   = 1'b0;
    busy_n   = busy_q;
    err_n    = err_q;
    load     = 1'b0;
    load_val = d_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          mode_n = mode_e'(bus.mode);
          lo_n   = bus.code_lo;
          hi_n   = bus.code_hi;
          d_n    = dw_in;
          if (bus.code_lo > bus.code_hi) begin
            err_n = 1'b1;
          end else begin
            err_n    = 1'b0;
            busy_n   = 1'b1;
            step_n   = 1'b1;
            load     = 1'b1;
            load_val = dw_in;
            if (mode_e'(bus.mode) == MODE_DOWN_ONCE) begin
              state_n = DOWN;
              code_n  = bus.code_hi;
            end else begin
              state_n = UP;
              code_n  = bus.code_lo;
            end
          end
        end
      end
      UP: begin
        if (bus.stop) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else if (expire) begin
          load = 1'b1;
          if (code_q < hi_q) begin
            code_n = code_q + 1'b1;
            step_n = 1'b1;
          end else if (mode_q == MODE_SAW) begin
            code_n = lo_q;
            per_n  = 1'b1;
            step_n = (lo_q != hi_q);
          end else if (mode_q == MODE_TRI) begin
            if (lo_q == hi_q) begin
              per_n = 1'b1;
            end else begin
              state_n = DOWN;
              code_n  = hi_q - 1'b1;
              step_n  = 1'b1;
            end
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      DOWN: begin
        if (bus.stop) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else if (expire) begin
          load = 1'b1;
          if (code_q > lo_q) begin
            code_n = code_q - 1'b1;
            step_n = 1'b1;
          end else if (mode_q == MODE_TRI) begin
            state_n = UP;
            code_n  = lo_q + 1'b1;
            step_n  = 1'b1;
            per_n   = 1'b1;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.code       = code_q;
  assign bus.step_stb   = step_q;
  assign bus.period_stb = per_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cfg_err    = err_q;

endmodule

// File: tb/tb_dac4_sweep_ctrl.sv
// Bench for dac4_sweep_ctrl: vector table,
// directed runs and random runs vs. a waveform model.
module tb_dac4_sweep_ctrl;

  typedef struct packed {
    int code;
    bit step;
    bit period;
    bit busy;
    bit done;
    bit err;
  } exp_t;

  typedef struct packed {
    bit   start;
    bit   stop;
    int   mode;
    int   lo;
    int   hi;
    int   dw;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  dac4_sweep_ctrl_if bus ();

  dac4_sweep_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk_e(int code, bit step, bit period,
                                bit busy, bit done, bit err);
    exp_t e;
    e.code = code; e.step = step; e.period = period;
    e.busy = busy; e.done = done; e.err = err;
    return e;
  endfunction

  function automatic vec_t mk_v(bit start, bit stop, int mode,
                                int lo, int hi, int dw, exp_t e);
    vec_t v;
    v.start = start; v.stop = stop; v.mode = mode;
    v.lo = lo; v.hi = hi; v.dw = dw; v.e = e;
    return v;
  endfunction

  // Expected outputs t cycles after the start edge.
  function automatic exp_t model(int md, int lo, int hi, int dw, int t);
    exp_t e;
    int d, n, r, w, m;
    bit s;
    d = (dw == 0) ? 1 : dw;
    n = t / d;
    r = t % d;
    s = (r == 0);
    w = hi - lo;
    e = mk_e(0, 0, 0, 0, 0, 0);
    case (md)
      0, 3: begin
        if (t < (w + 1) * d) begin
          e.code = (md == 0) ? lo + n : hi - n;
          e.busy = 1;
          e.step = s;
        end else begin
          e.code = (md == 0) ? hi : lo;
          e.done = (t == (w + 1) * d);
        end
      end
      1: begin
        e.code = lo + n % (w + 1);
        e.busy = 1;
        e.step = s && (n == 0 || w > 0);
        e.period = s && n > 0 && (n % (w + 1) == 0);
      end
      default: begin
        e.busy = 1;
        if (w == 0) begin
          e.code = lo;
          e.step = (t == 0);
          e.period = s && n > 0;
        end else begin
          m = n % (2 * w);
          e.code = (m <= w) ? lo + m : lo + 2 * w - m;
          e.step = s;
          e.period = s && m == 1 && n > 1;
        end
      end
    endcase
    return e;
  endfunction

  task automatic check(string nm, exp_t e);
    vectors++;
    if (int'(bus.code) != e.code || bus.step_stb != e.step ||
        bus.period_stb != e.period || bus.busy != e.busy ||
        bus.done != e.done || bus.cfg_err != e.err) begin
      miscompares++;
      $display("FAIL %s @%0t: got code=%0d stp=%0b per=%0b busy=%0b done=%0b err=%0b, want code=%0d stp=%0b per=%0b busy=%0b done=%0b err=%0b",
               nm, $time, bus.code, bus.step_stb, bus.period_stb,
               bus.busy, bus.done, bus.cfg_err, e.code, e.step,
               e.period, e.busy, e.done, e.err);
    end
  endtask

  task automatic check_int(string nm, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic run(input int md, input int lo, input int hi,
                     input int dw, input int ncyc, input bit do_stop,
                     input bit noise, input string nm,
                     output int nstep, output int nbusy);
    exp_t e, last;
    nstep = 0;
    nbusy = 0;
    bus.start = 1'b1;
    bus.stop = 1'b0;
    bus.mode = 2'(md);
    bus.code_lo = 4'(lo);
    bus.code_hi = 4'(hi);
    bus.dwell = 8'(dw);
    tick();
    bus.start = 1'b0;
    e = model(md, lo, hi, dw, 0);
    check(nm, e);
    last = e;
    nstep += int'(bus.step_stb);
    nbusy += int'(bus.busy);
    for (int t = 1; t <= ncyc; t++) begin
      if (noise) begin
        bus.start = ($urandom_range(0, 2) == 0);
        bus.mode = 2'($urandom);
        bus.code_lo = 4'($urandom);
        bus.code_hi = 4'($urandom);
        bus.dwell = 8'($urandom);
      end
      tick();
      e = model(md, lo, hi, dw, t);
      check(nm, e);
      last = e;
      nstep += int'(bus.step_stb);
      nbusy += int'(bus.busy);
    end
    bus.start = 1'b0;
    if (do_stop) begin
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      e = mk_e(last.code, 0, 0, 0, 0, 0);
      check({nm, "_stop"}, e);
    end
  endtask

  initial begin
    vec_t tbl[$];
    int ns, nb, md, lo, hi, dw;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.mode = '0;
    bus.code_lo = '0;
    bus.code_hi = '0;
    bus.dwell = '0;

    tbl.push_back(mk_v(1, 0, 0, 9, 4, 1, mk_e(0, 0, 0, 0, 0, 1)));
    tbl.push_back(mk_v(1, 0, 3, 4, 9, 1, mk_e(9, 1, 0, 1, 0, 0)));
    tbl.push_back(mk_v(0, 0, 0, 0, 0, 0, mk_e(8, 1, 0, 1, 0, 0)));
    tbl.push_back(mk_v(1, 0, 0, 0, 0, 0, mk_e(7, 1, 0, 1, 0, 0)));
    tbl.push_back(mk_v(0, 0, 0, 0, 0, 0, mk_e(6, 1, 0, 1, 0, 0)));
    tbl.push_back(mk_v(0, 0, 0, 0, 0, 0, mk_e(5, 1, 0, 1, 0, 0)));
    tbl.push_back(mk_v(0, 0, 0, 0, 0, 0, mk_e(4, 1, 0, 1, 0, 0)));
    tbl.push_back(mk_v(0, 0, 0, 0, 0, 0, mk_e(4, 0, 0, 0, 1, 0)));
    tbl.push_back(mk_v(0, 0, 0, 0, 0, 0, mk_e(4, 0, 0, 0, 0, 0)));
    tbl.push_back(mk_v(1, 1, 1, 0, 3, 1, mk_e(4, 0, 0, 0, 0, 0)));
    tbl.push_back(mk_v(0, 1, 0, 0, 0, 0, mk_e(4, 0, 0, 0, 0, 0)));
    tbl.push_back(mk_v(1, 0, 1, 5, 2, 1, mk_e(4, 0, 0, 0, 0, 1)));
    tbl.push_back(mk_v(0, 0, 0, 0, 0, 0, mk_e(4, 0, 0, 0, 0, 1)));

    tick();
    tick();
    check("reset", mk_e(0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle", mk_e(0, 0, 0, 0, 0, 0));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      bus.start = tbl[i].start;
      bus.stop = tbl[i].stop;
      bus.mode = 2'(tbl[i].mode);
      bus.code_lo = 4'(tbl[i].lo);
      bus.code_hi = 4'(tbl[i].hi);
      bus.dwell = 8'(tbl[i].dw);
      tick();
      check($sformatf("tbl%0d", i), tbl[i].e);
    end
    bus.start = 1'b0;
    bus.stop = 1'b0;

    rst = 1'b1;
    tick();
    check("rst_err", mk_e(0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    run(0, 0, 15, 5, 82, 1, 0, "ramp_up", ns, nb);
    check_int("ramp_up_steps", ns, 16);
    check_int("ramp_up_busy", nb, 80);

    run(2, 2, 5, 0, 30, 1, 0, "tri", ns, nb);

    run(1, 3, 6, 2, 4, 1, 0, "saw_stop", ns, nb);
    check_int("saw_stop_code", int'(bus.code), 5);

    run(1, 0, 15, 3, $urandom_range(5, 40), 0, 1, "saw_noise", ns, nb);
    rst = 1'b1;
    tick();
    check("rst_mid", mk_e(0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    for (int k = 0; k < 24; k++) begin
      md = $urandom_range(0, 3);
      lo = $urandom_range(0, 15);
      hi = $urandom_range(lo, 15);
      dw = $urandom_range(0, 3);
      run(md, lo, hi, dw, $urandom_range(0, 60), 1, 0,
          $sformatf("rnd%0d", k), ns, nb);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
